sevseg_scan: RTL and testbench

Time-multiplexed scan controller for an NDIG-digit common-segment seven-segment display.
- Sequences one shared BCD-to-seven-segment decoder across all digits: drives its 4-bit DIG and EN inputs and a one-hot digit-select bus AN.
- Provides an inter-digit blanking gap, leading-zero blanking, and frame-synchronous (tear-free) data update via a LOAD/PEND handshake.

---
 rtl/sevseg_scan.sv | 146 ++++++++++++++
 tb/tb_sevseg_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sevseg_scan.sv
// sevseg_scan: time-multiplexed scan controller for an NDIG-digit
// seven-segment display. One shared decoder is fed per digit slot; each
// slot opens with a short blanking gap. New data is staged in a pending
// register and only committed to the displayed (shadow) copy at a frame
// boundary or while idle, so a scan never mixes old and new digits.
module sevseg_scan #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 1000,
    parameter int BLANK    = 16
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [4*NDIG-1:0]   DATA,
    input  logic                LOAD,
    input  logic                ON,
    input  logic                LZB,
    output logic [3:0]          DIG,
    output logic                EN,
    output logic [NDIG-1:0]     AN,
    output logic                FRAME,
    output logic                PEND
);

    localparam int IW = $clog2(NDIG);
    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(BLANK - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     idx, idx_nx;
    logic [CW-1:0]     cnt, cnt_nx;
    logic [4*NDIG-1:0] shadow, pending;
    logic              pend;
    logic              lzb_q;
    logic              frame_end;
    logic [3:0]        cur;
    logic              upper_nz;
    logic              visible;

    // Scan sequencer registers: state, digit index, slot counter.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; cnt runs 0..PRESCALE-1 across the whole slot.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt;
        if (!ON) begin
            state_nx = IDLE;
            idx_nx   = '0;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx = GAP;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
                GAP: begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == GAP_LAST) state_nx = SHOW;
                end
                SHOW: begin
                    if (cnt == CNT_LAST) begin
                        state_nx = GAP;
                        cnt_nx   = '0;
                        idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    assign frame_end = (state == SHOW) && (idx == IDX_LAST) && (cnt == CNT_LAST);

    // Data path: pending capture, frame-synchronous commit, LZB sampling.
    // A LOAD on the commit edge overrides the pend clear (later NBA wins).
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            shadow  <= '0;
            pending <= '0;
            pend    <= 1'b0;
            lzb_q   <= 1'b0;
        end else begin
            lzb_q <= LZB;
            if ((frame_end || state == IDLE) && pend) begin
                shadow <= pending;
                pend   <= 1'b0;
            end
            if (LOAD) begin
                pending <= DATA;
                pend    <= 1'b1;
            end
        end
    end

    // Current digit value and its visibility (invalid code / leading zero).
    always_comb begin
        cur      = '0;
        upper_nz = 1'b0;
        for (int unsigned i = 0; i < NDIG; i++) begin
            if (IW'(i) == idx) cur = shadow[4*i +: 4];
            if ((i >= 32'(idx)) && (shadow[4*i +: 4] != 4'd0)) upper_nz = 1'b1;
        end
        visible = (cur <= 4'd9) && !((idx != '0) && lzb_q && !upper_nz);
    end

    // Output decode from registered state only.
    always_comb begin
        AN    = '0;
        EN    = 1'b0;
        DIG   = '0;
        FRAME = frame_end;
        PEND  = pend;
        case (state)
            GAP: DIG = cur;
            SHOW: begin
                for (int unsigned i = 0; i < NDIG; i++) AN[i] = (IW'(i) == idx);
                DIG = cur;
                EN  = visible;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sevseg_scan.sv
// Testbench for sevseg_scan (NDIG=4, PRESCALE=8, BLANK=2, 32-cycle frame).
// The reference model tracks a position counter within the frame and
// derives the expected outputs arithmetically from it.
module tb_sevseg_scan;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] DATA = '0;
    logic        LOAD = 1'b0;
    logic        ON = 1'b0;
    logic        LZB = 1'b0;
    logic [3:0]  DIG;
    logic        EN;
    logic [3:0]  AN;
    logic        FRAME;
    logic        PEND;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_run  = 1'b0;
    int          m_t    = 0;
    logic [15:0] m_sh   = '0;
    logic [15:0] m_pd   = '0;
    bit          m_pend = 1'b0;
    bit          m_lzb  = 1'b0;

    // stimulus settings used by run()
    bit          on_v  = 1'b0;
    bit          lzb_v = 1'b0;

    sevseg_scan #(.NDIG(4), .PRESCALE(8), .BLANK(2)) dut (
        .CLK(CLK), .RESET(RESET), .DATA(DATA), .LOAD(LOAD), .ON(ON),
        .LZB(LZB), .DIG(DIG), .EN(EN), .AN(AN), .FRAME(FRAME), .PEND(PEND)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_t = 0; m_sh = '0; m_pd = '0; m_pend = 0; m_lzb = 0;
    endtask

    task automatic compare_outputs();
        int slot, pos;
        logic [3:0] d;
        bit vis;
        logic [3:0] e_an, e_dig;
        bit e_en, e_fr;
        slot = m_t / 8;
        pos  = m_t % 8;
        d    = 4'((m_sh >> (4 * slot)) & 16'hF);
        vis  = (d <= 9) && !(slot > 0 && m_lzb && ((m_sh >> (4 * slot)) == 16'h0));
        e_an = '0; e_dig = '0; e_en = 0; e_fr = 0;
        if (m_run) begin
            e_dig = d;
            e_fr  = (m_t == 31);
            if (pos >= 2) begin
                e_an = 4'(1 << slot);
                e_en = vis;
            end
        end
        check("AN", 32'(AN), 32'(e_an));
        check("DIG", 32'(DIG), 32'(e_dig));
        check("EN", 32'(EN), 32'(e_en));
        check("FRAME", 32'(FRAME), 32'(e_fr));
        check("PEND", 32'(PEND), 32'(m_pend));
    endtask

    // One clock: check at negedge, apply inputs, advance model at posedge.
    task automatic cyc(input bit on_i, input bit load_i, input logic [15:0] data_i, input bit lzb_i);
        bit commit;
        @(negedge CLK);
        compare_outputs();
        ON = on_i; LOAD = load_i; DATA = data_i; LZB = lzb_i;
        @(posedge CLK);
        commit = (!m_run || m_t == 31) && m_pend;
        if (commit) begin
            m_sh   = m_pd;
            m_pend = 0;
        end
        if (load_i) begin
            m_pd   = data_i;
            m_pend = 1;
        end
        m_lzb = lzb_i;
        if (!on_i) begin
            m_run = 0; m_t = 0;
        end else if (!m_run) begin
            m_run = 1; m_t = 0;
        end else begin
            m_t = (m_t + 1) % 32;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(on_v, 1'b0, DATA, lzb_v);
    endtask

    task automatic load_now(input logic [15:0] d);
        cyc(on_v, 1'b1, d, lzb_v);
    endtask

    // Advance until the model sits at frame position 'target' (bounded).
    task automatic wait_t(input int target);
        int n = 0;
        bit found;
        while (!(m_run && m_t == target) && n < 80) begin
            cyc(on_v, 1'b0, DATA, lzb_v);
            n++;
        end
        found = m_run && (m_t == target);
        check("wait_pos", 32'(found), 32'd1);
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
                0: r[4*i +: 4] = 4'd0;
                1, 2: r[4*i +: 4] = 4'($urandom_range(0, 9));
                default: r[4*i +: 4] = 4'($urandom_range(0, 15));
            endcase
        end
        return r;
    endfunction

    initial begin
        model_reset();
        @(posedge CLK);
        #2 RESET = 1'b0;

        // idle with display off
        on_v = 0; lzb_v = 0;
        run(50);

        // basic scan of 1234
        load_now(16'h1234);
        run(2);
        on_v = 1;
        run(40);

        // frame-synchronous update requested during digit 1
        wait_t(11);
        load_now(16'h5678);
        wait_t(31);
        run(40);

        // LOAD coincident with FRAME
        wait_t(10);
        load_now(16'h1111);
        wait_t(31);
        load_now(16'h2222);
        run(70);

        // leading-zero blanking and invalid codes
        lzb_v = 1;
        load_now(16'h0070);
        run(70);
        load_now(16'h0000);
        run(70);
        lzb_v = 0;
        run(40);
        load_now(16'h1A3F);
        run(70);

        // ON drop during digit 2 SHOW, then re-enable
        wait_t(20);
        on_v = 0;
        run(3);
        on_v = 1;
        run(40);

        // asynchronous reset mid-SHOW with pending data
        wait_t(3);
        load_now(16'h4321);
        @(negedge CLK);
        #2 RESET = 1'b1;
        ON = 1'b0;
        #1;
        model_reset();
        check("rst_AN", 32'(AN), 32'd0);
        check("rst_EN", 32'(EN), 32'd0);
        check("rst_DIG", 32'(DIG), 32'd0);
        check("rst_PEND", 32'(PEND), 32'd0);
        @(posedge CLK);
        #2 RESET = 1'b0;
        on_v = 0;
        run(50);

        // randomized operation
        on_v = 1;
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(0, 99) < 2) on_v = ~on_v;
            if ($urandom_range(0, 99) < 3) lzb_v = ~lzb_v;
            if ($urandom_range(0, 99) < 6) load_now(rand_data());
            else run(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
